// File: rtl/matcher_list_scanner_if.sv
//------------------------------------------------------------------------------
// matcher_list_scanner_if
//
// Purpose: bundles the scanner's control-side and ROM-side signals so that the
// scanner and its environment can be connected through one port.
//
// Signals:
//   start      scan request from the matcher control logic
//   key        value to match
//   mask       compare mask, 1 = bit compared
//   count      number of entries to scan (LIST_WIDTH+1 bits)
//   rom_enable ROM read enable, driven by the scanner
//   rom_addr   ROM read address, driven by the scanner
//   rom_data   ROM read data, one cycle after enable/addr
//   busy       scan in progress
//   done       one-cycle completion pulse
//   hit        match found in the last scan
//   hit_index  address of the first matching entry
//   hit_data   full ROM word of the first matching entry
//
// Modports:
//   master  control logic plus ROM side (drives requests and ROM data)
//   slave   the scanner itself
//------------------------------------------------------------------------------
interface matcher_list_scanner_if #(
  parameter int LIST_WIDTH = 10,
  parameter int DATA_WIDTH = 64
);
  logic                  start;
  logic [DATA_WIDTH-1:0] key;
  logic [DATA_WIDTH-1:0] mask;
  logic [LIST_WIDTH:0]   count;
  logic                  rom_enable;
  logic [LIST_WIDTH-1:0] rom_addr;
  logic [DATA_WIDTH-1:0] rom_data;
  logic                  busy;
  logic                  done;
  logic                  hit;
  logic [LIST_WIDTH-1:0] hit_index;
  logic [DATA_WIDTH-1:0] hit_data;

  modport master (
    output start, key, mask, count, rom_data,
    input  rom_enable, rom_addr, busy, done, hit, hit_index, hit_data
  );

  modport slave (
    input  start, key, mask, count, rom_data,
    output rom_enable, rom_addr, busy, done, hit, hit_index, hit_data
  );
endinterface

// File: rtl/matcher_list_scanner.sv
//------------------------------------------------------------------------------
// matcher_list_scanner
//
// Purpose: on an accepted start, latches key/mask/count and walks the matcher
// list ROM from address 0 upward, one address per cycle. Each returned word is
// compared under the mask; the first match ends the scan and is reported as
// hit/hit_index/hit_data. The ROM has a one-cycle registered read, so a valid
// bit carrying the issued address follows each read by one cycle.
//
// Ports:
//   fclk  clock, all state on the rising edge
//   rst   asynchronous active-high reset
//   bus   matcher_list_scanner_if.slave (request, ROM and result signals)
//
// Cycle 0 is the cycle in which start is sampled in IDLE. Address a is on
// rom_addr in cycle a+1 and its data is compared in cycle a+2. A hit at index
// k gives done in cycle k+3; a miss gives done in cycle count+2.
//------------------------------------------------------------------------------
module matcher_list_scanner #(
  parameter int LIST_WIDTH = 10,
  parameter int DATA_WIDTH = 64
) (
  input  logic                    fclk,
  input  logic                    rst,
  matcher_list_scanner_if.slave   bus
);

  // Full list depth, expressed in the width of the count input.
  localparam logic [LIST_WIDTH:0] DEPTH = {1'b1, {LIST_WIDTH{1'b0}}};
  localparam logic [LIST_WIDTH:0] ONE_C = {{LIST_WIDTH{1'b0}}, 1'b1};
  localparam logic [LIST_WIDTH-1:0] ONE_A = {{(LIST_WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SCAN  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;

  logic [DATA_WIDTH-1:0] r_key;
  logic [DATA_WIDTH-1:0] r_mask;
  logic [LIST_WIDTH-1:0] r_last;      // last address to issue (clamped count - 1)

  logic                  r_vld;       // rom_data this cycle belongs to a scan read
  logic [LIST_WIDTH-1:0] r_vaddr;     // address that produced the current rom_data

  logic                  r_rom_enable;
  logic [LIST_WIDTH-1:0] r_rom_addr;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_hit;
  logic [LIST_WIDTH-1:0] r_hit_index;
  logic [DATA_WIDTH-1:0] r_hit_data;

  logic                  w_accept;
  logic                  w_match;
  logic                  w_scan_last;
  logic [LIST_WIDTH:0]   w_count_clamped;
  logic [LIST_WIDTH-1:0] w_addr_nxt;

  assign w_accept        = (r_state == ST_IDLE) && bus.start;
  assign w_count_clamped = (bus.count > DEPTH) ? DEPTH : bus.count;
  assign w_scan_last     = (r_rom_addr == r_last);
  // Only qualified reads can match, so the zero data the ROM returns while
  // disabled never counts as a hit even with mask = 0.
  assign w_match = r_vld &&
                   (((bus.rom_data ^ r_key) & r_mask) == {DATA_WIDTH{1'b0}});

  // Next-state logic for the scan sequencer.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (bus.start) begin
          if (bus.count == {(LIST_WIDTH+1){1'b0}}) begin
            w_state_nxt = ST_DONE;
          end else begin
            w_state_nxt = ST_SCAN;
          end
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_SCAN: begin
        // A match ends the scan at once; the read issued this cycle is dropped.
        if (w_match) begin
          w_state_nxt = ST_DONE;
        end else if (w_scan_last) begin
          w_state_nxt = ST_DRAIN;
        end else begin
          w_state_nxt = ST_SCAN;
        end
      end
      // DRAIN holds exactly the final compare, hit or miss.
      ST_DRAIN: w_state_nxt = ST_DONE;
      ST_DONE:  w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // Next ROM address: 0 outside SCAN, increments while SCAN continues.
  always_comb begin
    w_addr_nxt = {LIST_WIDTH{1'b0}};
    if ((w_state_nxt == ST_SCAN) && (r_state == ST_SCAN)) begin
      // SCAN->SCAN only happens below r_last, so this never wraps.
      w_addr_nxt = r_rom_addr + ONE_A;
    end else begin
      w_addr_nxt = {LIST_WIDTH{1'b0}};
    end
  end

  // State register.
  always_ff @(posedge fclk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Latch key, mask and last address on an accepted start.
  always_ff @(posedge fclk or posedge rst) begin
    if (rst) begin
      r_key  <= {DATA_WIDTH{1'b0}};
      r_mask <= {DATA_WIDTH{1'b0}};
      r_last <= {LIST_WIDTH{1'b0}};
    end else if (w_accept) begin
      r_key  <= bus.key;
      r_mask <= bus.mask;
      r_last <= LIST_WIDTH'(w_count_clamped - ONE_C);
    end else begin
      r_key  <= r_key;
      r_mask <= r_mask;
      r_last <= r_last;
    end
  end

  // Read-valid pipeline matching the ROM's one-cycle read latency.
  always_ff @(posedge fclk or posedge rst) begin
    if (rst) begin
      r_vld   <= 1'b0;
      r_vaddr <= {LIST_WIDTH{1'b0}};
    end else begin
      r_vld   <= (r_state == ST_SCAN) && (w_state_nxt != ST_DONE);
      r_vaddr <= r_rom_addr;
    end
  end

  // Registered ROM controls and status outputs, decoded from the next state.
  always_ff @(posedge fclk or posedge rst) begin
    if (rst) begin
      r_rom_enable <= 1'b0;
      r_rom_addr   <= {LIST_WIDTH{1'b0}};
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_rom_enable <= (w_state_nxt == ST_SCAN);
      r_rom_addr   <= w_addr_nxt;
      r_busy       <= (w_state_nxt == ST_SCAN) || (w_state_nxt == ST_DRAIN);
      r_done       <= (w_state_nxt == ST_DONE);
    end
  end

  // Result registers: cleared on accepted start, set on the first match.
  always_ff @(posedge fclk or posedge rst) begin
    if (rst) begin
      r_hit       <= 1'b0;
      r_hit_index <= {LIST_WIDTH{1'b0}};
      r_hit_data  <= {DATA_WIDTH{1'b0}};
    end else if (w_accept) begin
      r_hit       <= 1'b0;
      r_hit_index <= {LIST_WIDTH{1'b0}};
      r_hit_data  <= {DATA_WIDTH{1'b0}};
    end else if (w_match && ((r_state == ST_SCAN) || (r_state == ST_DRAIN))) begin
      r_hit       <= 1'b1;
      r_hit_index <= r_vaddr;
      r_hit_data  <= bus.rom_data;
    end else begin
      r_hit       <= r_hit;
      r_hit_index <= r_hit_index;
      r_hit_data  <= r_hit_data;
    end
  end

  assign bus.rom_enable = r_rom_enable;
  assign bus.rom_addr   = r_rom_addr;
  assign bus.busy       = r_busy;
  assign bus.done       = r_done;
  assign bus.hit        = r_hit;
  assign bus.hit_index  = r_hit_index;
  assign bus.hit_data   = r_hit_data;

endmodule

// File: tb/tb_matcher_list_scanner.sv
//------------------------------------------------------------------------------
// tb_matcher_list_scanner
//
// Directed bench for matcher_list_scanner with a registered-read ROM model.
// A table of scan vectors is applied in a loop; reset and handshake corner
// cases are written out as separate sequences.
//------------------------------------------------------------------------------
module tb_matcher_list_scanner;

  localparam int LW = 10;
  localparam int DW = 64;
  localparam int LIMIT = 1200;

  logic fclk;
  logic rst;

  matcher_list_scanner_if #(.LIST_WIDTH(LW), .DATA_WIDTH(DW)) bus ();

  matcher_list_scanner #(.LIST_WIDTH(LW), .DATA_WIDTH(DW)) dut (
    .fclk (fclk),
    .rst  (rst),
    .bus  (bus)
  );

  initial fclk = 1'b0;
  always #5 fclk = ~fclk;

  // ROM model: one-cycle registered read, zero output when not enabled.
  logic [DW-1:0] rom_mem [0:(1<<LW)-1];
  always_ff @(posedge fclk) begin
    if (bus.rom_enable) bus.rom_data <= rom_mem[bus.rom_addr];
    else                bus.rom_data <= 64'h0;
  end

  typedef struct {
    string          name;
    logic [DW-1:0]  key;
    logic [DW-1:0]  mask;
    logic [LW:0]    count;
    logic           exp_hit;
    logic [LW-1:0]  exp_idx;
    logic [DW-1:0]  exp_data;
    int             exp_done;   // cycle of the done pulse
    int             exp_reads;  // number of enabled ROM reads (addresses 0..n-1)
  } vec_t;

  vec_t vecs [8];
  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge fclk);
    #1;
  endtask

  // Apply one scan and check timing, address sequence and result.
  task automatic run_vec(input vec_t v);
    int  cyc;
    int  n_rd;
    int  last_a;
    int  done_cyc;
    bit  seq_ok;
    bit  overlap;
    bit  busy_ok;
    bit  early;
    n_rd = 0; last_a = -1; done_cyc = -1;
    seq_ok = 1'b1; overlap = 1'b0; busy_ok = 1'b1; early = 1'b0;
    bus.key = v.key; bus.mask = v.mask; bus.count = v.count; bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    cyc = 1;
    while (cyc < LIMIT) begin
      if (bus.rom_enable) begin
        if ((int'(bus.rom_addr) != n_rd) || (cyc != n_rd + 1)) seq_ok = 1'b0;
        last_a = int'(bus.rom_addr);
        n_rd++;
      end
      if (bus.busy && bus.done) overlap = 1'b1;
      if (bus.done) begin
        done_cyc = cyc;
        break;
      end
      if (!bus.busy) busy_ok = 1'b0;
      if (bus.hit || (bus.hit_index != 10'd0) || (bus.hit_data != 64'd0)) early = 1'b1;
      step();
      cyc++;
    end
    check({v.name, "_done_cycle"}, 64'(done_cyc), 64'(v.exp_done));
    check({v.name, "_hit"},        64'(bus.hit), 64'(v.exp_hit));
    check({v.name, "_hit_index"},  64'(bus.hit_index), 64'(v.exp_idx));
    check({v.name, "_hit_data"},   bus.hit_data, v.exp_data);
    check({v.name, "_reads"},      64'(n_rd), 64'(v.exp_reads));
    check({v.name, "_last_addr"},  64'(last_a), 64'(v.exp_reads - 1));
    check({v.name, "_addr_seq"},   64'(seq_ok), 64'd1);
    check({v.name, "_busy_high"},  64'(busy_ok), 64'd1);
    check({v.name, "_busy_done"},  64'(overlap), 64'd0);
    check({v.name, "_cleared"},    64'(early), 64'd0);
    step();
    check({v.name, "_done_pulse"}, 64'(bus.done), 64'd0);
    check({v.name, "_hit_held"},   64'(bus.hit), 64'(v.exp_hit));
  endtask

  function automatic vec_t mk(input string n, input logic [DW-1:0] k, input logic [DW-1:0] m,
                              input logic [LW:0] c, input logic h, input logic [LW-1:0] i,
                              input logic [DW-1:0] d, input int dc, input int nr);
    vec_t v;
    v.name = n; v.key = k; v.mask = m; v.count = c; v.exp_hit = h; v.exp_idx = i;
    v.exp_data = d; v.exp_done = dc; v.exp_reads = nr;
    return v;
  endfunction

  initial begin : main
    int cyc;
    int done_cyc;
    bit saw_done;
    logic [DW-1:0] all1;
    all1 = {DW{1'b1}};

    for (int i = 0; i < (1 << LW); i++) rom_mem[i] = 64'hA5A5_0000_0000_0000 | 64'(i);
    rom_mem[5] = 64'hDEAD_BEEF_0000_0005;
    rom_mem[3] = 64'h1111_0000_0000_1234;
    rom_mem[7] = 64'h2222_0000_0000_1234;

    vecs[0] = mk("hit5",     64'hDEAD_BEEF_0000_0005, all1, 11'd16, 1'b1, 10'd5, 64'hDEAD_BEEF_0000_0005, 8, 7);
    vecs[1] = mk("miss4",    all1, all1, 11'd4,  1'b0, 10'd0, 64'h0, 6, 4);
    vecs[2] = mk("count0",   all1, all1, 11'd0,  1'b0, 10'd0, 64'h0, 1, 0);
    vecs[3] = mk("mask0",    64'h0, 64'h0, 11'd16, 1'b1, 10'd0, 64'hA5A5_0000_0000_0000, 3, 2);
    vecs[4] = mk("priority", 64'h0000_0000_0000_1234, 64'h0000_0000_0000_FFFF, 11'd16,
                 1'b1, 10'd3, 64'h1111_0000_0000_1234, 6, 5);
    vecs[5] = mk("clamp",    all1, all1, 11'd1029, 1'b0, 10'd0, 64'h0, 1026, 1024);
    vecs[6] = mk("hitlast",  64'h2222_0000_0000_1234, all1, 11'd8, 1'b1, 10'd7, 64'h2222_0000_0000_1234, 10, 8);
    vecs[7] = mk("count1",   all1, all1, 11'd1,  1'b0, 10'd0, 64'h0, 3, 1);

    // Reset values.
    rst = 1'b1; bus.start = 1'b0; bus.key = 64'h0; bus.mask = 64'h0; bus.count = 11'd0;
    step(); step();
    check("rst_rom_enable", 64'(bus.rom_enable), 64'd0);
    check("rst_rom_addr",   64'(bus.rom_addr),   64'd0);
    check("rst_busy",       64'(bus.busy),       64'd0);
    check("rst_done",       64'(bus.done),       64'd0);
    check("rst_hit",        64'(bus.hit),        64'd0);
    check("rst_hit_index",  64'(bus.hit_index),  64'd0);
    check("rst_hit_data",   bus.hit_data,        64'd0);
    rst = 1'b0;
    step();

    for (int i = 0; i < 8; i++) run_vec(vecs[i]);

    // Reset while idle with a held hit: results clear without a clock edge.
    run_vec(vecs[0]);
    rst = 1'b1;
    #1;
    check("idle_rst_hit",       64'(bus.hit),       64'd0);
    check("idle_rst_hit_index", 64'(bus.hit_index), 64'd0);
    check("idle_rst_hit_data",  bus.hit_data,       64'd0);
    step();
    rst = 1'b0;
    step();

    // Reset mid-scan: immediate abort, no done pulse, next start from address 0.
    bus.key = all1; bus.mask = all1; bus.count = 11'd16; bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    step(); step(); step();
    check("scan_before_rst_busy", 64'(bus.busy), 64'd1);
    rst = 1'b1;
    #1;
    check("scan_rst_busy",       64'(bus.busy),       64'd0);
    check("scan_rst_rom_enable", 64'(bus.rom_enable), 64'd0);
    check("scan_rst_rom_addr",   64'(bus.rom_addr),   64'd0);
    saw_done = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      if (bus.done) saw_done = 1'b1;
    end
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      if (bus.done || bus.busy) saw_done = 1'b1;
    end
    check("scan_rst_no_activity", 64'(saw_done), 64'd0);
    run_vec(vecs[0]);

    // Start pulses during SCAN and DONE are ignored; results hold afterwards.
    bus.key = 64'hDEAD_BEEF_0000_0005; bus.mask = all1; bus.count = 11'd16; bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    cyc = 1; done_cyc = -1;
    while (cyc < 40) begin
      if (cyc == 3) begin
        bus.start = 1'b1; bus.key = 64'h0; bus.mask = 64'h0; bus.count = 11'd2;
      end else begin
        bus.start = 1'b0;
      end
      if (bus.done) begin
        done_cyc = cyc;
        bus.start = 1'b1;
        break;
      end
      step();
      cyc++;
    end
    check("hs_done_cycle", 64'(done_cyc), 64'd8);
    check("hs_hit_index",  64'(bus.hit_index), 64'd5);
    step();
    bus.start = 1'b0;
    check("hs_after_done_pulse", 64'(bus.done),  64'd0);
    check("hs_after_done_busy",  64'(bus.busy),  64'd0);
    step();
    check("hs_idle_rom_enable", 64'(bus.rom_enable), 64'd0);
    check("hs_idle_busy",       64'(bus.busy),       64'd0);
    check("hs_held_hit",        64'(bus.hit),        64'd1);
    check("hs_held_index",      64'(bus.hit_index),  64'd5);
    check("hs_held_data",       bus.hit_data,        64'hDEAD_BEEF_0000_0005);
    run_vec(vecs[1]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/matcher_list_scanner.md
# matcher_list_scanner

Sequencer for the matcher list ROM: on a start request it latches a key/mask pair and walks the ROM from address 0 upward, one address per cycle. It compares each returned entry under the mask, stops at the first match, and reports hit, index and entry. It sits between the matcher's control logic and the ROM instance, owns the ROM's `enable`/`addr` inputs, and accounts for the ROM's one-cycle registered read.

## Interface
- `LIST_WIDTH`, 10, ROM address width; list depth is 2^LIST_WIDTH.
- `DATA_WIDTH`, 64, entry/key width.

- `fclk`  in  1  clock; all state on rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `start`  in  1  scan request; accepted only in IDLE.
- `key`  in  DATA_WIDTH  value to match; latched on accepted start.
- `mask`  in  DATA_WIDTH  compare mask (1 = bit compared); latched on accepted start.
- `count`  in  LIST_WIDTH+1  number of entries to scan; latched on accepted start.
- `rom_enable`  out  1  drives ROM `enable`.
- `rom_addr`  out  LIST_WIDTH  drives ROM `addr`.
- `rom_data`  in  DATA_WIDTH  ROM `data_out`.
- `busy`  out  1  scan in progress.
- `done`  out  1  one-cycle completion pulse.
- `hit`  out  1  match found in last scan.
- `hit_index`  out  LIST_WIDTH  address of first matching entry.
- `hit_data`  out  DATA_WIDTH  full (unmasked) ROM word of matching entry.

## Operation
- States: IDLE, SCAN, DRAIN, DONE.
- IDLE:
  - `start`=1 latches key, mask and count.
  - Latched count is clamped to 2^LIST_WIDTH if larger.
  - Clears hit, hit_index and hit_data.
  - Goes to SCAN, or to DONE if count=0.
- SCAN:
  - rom_enable=1, rom_addr = next address.
  - Address increments each cycle.
  - After issuing address count-1, go to DRAIN.
- DRAIN: rom_enable=0; waits for the final compare.
- Compare:
  - Performed in SCAN and DRAIN on `rom_data`, qualified by a one-cycle-delayed valid bit.
  - Valid bit also carries the issued address.
  - Match when ((rom_data ^ key) & mask) == 0.
  - Unqualified zero data (ROM enable low) never produces a match.
- On first match (in SCAN or DRAIN):
  - Register hit=1, hit_index = carried address, hit_data = rom_data.
  - Go to DONE; the in-flight read is discarded.
- Last compare without a match: go to DONE with hit=0.
- DONE: done=1 for exactly one cycle, then IDLE.
- Result holding: hit, hit_index and hit_data hold until the next accepted start.
- Outside SCAN: rom_addr returns to 0.
- Lowest matching index always wins; mask=0 matches entry 0.
- `start` in SCAN, DRAIN or DONE is ignored and not queued.

## Timing
- Cycle numbering: the cycle in which `start` is sampled high in IDLE is cycle 0.
- SCAN begins in cycle 1; address a is on `rom_addr` in cycle a+1.
- Read latency: `rom_data` for address a is compared in cycle a+2.
- Hit at index k: done=1 in cycle k+3.
- No hit: done=1 in cycle count+2.
- count=0: done=1 in cycle 1; rom_enable never asserts.
- busy=1 from cycle 1 through the last SCAN/DRAIN cycle; busy=0 in DONE and IDLE.
- busy and done are never both 1.
- Result outputs are stable and valid in the done cycle.
- Reset values: state IDLE; rom_enable, rom_addr, busy, done, hit, hit_index, hit_data all 0.
- Reset mid-scan: immediate abort, all outputs to reset values, no done pulse.
- Scan resumes only on a new start after reset release.
- Full-depth scan (count=2^LIST_WIDTH):
  - Last address is 2^LIST_WIDTH-1.
  - Address counter must not wrap to 0 and issue an extra read.
  - done in cycle 2^LIST_WIDTH+2.

## Test plan
- Reset: assert `rst` mid-idle and mid-scan → all outputs 0 asynchronously, no done pulse, next start scans from address 0.
- Hit: ROM entry 5 = 0xDEADBEEF_00000005, key equal, mask all-ones, count=16 → rom_addr 0..6 issued, done in cycle 8, hit=1, hit_index=5, hit_data=0xDEADBEEF_00000005.
- Miss: count=4, key absent → addresses 0..3, done in cycle 6, hit=0, hit_index=0, busy high cycles 1–5.
- Edge counts:
  - count=0 → done in cycle 1, rom_enable never high.
  - count=2^LIST_WIDTH+5 → clamped, last address 1023, done in cycle 1026.
- Mask/priority:
  - mask=0 → hit_index=0, done in cycle 3.
  - Entries 3 and 7 both match under mask 0xFFFF → hit_index=3.
- Handshake: start pulsed during SCAN and DONE → ignored; previous results held until next accepted start, which clears them in the following cycle.
